sha256_digest_ctrl: RTL and testbench
=====================================

// Module: sha256_digest_ctrl
// PURPOSE
//   Sequencer between the SHA-256 message buffer, the compression core and the UART
//   transmitter. Captures one padded 512-bit block when the buffer raises msg_ready and
//   starts the core. Latches the 256-bit digest when the core finishes, then streams it
//   MSB-byte-first as 32 bytes through the UART TX handshake. Includes a core watchdog.
// PARAMETERS
//   DIGEST_BYTES    32    bytes streamed per digest; the index counter is $clog2(DIGEST_BYTES) bits
//   TIMEOUT_CYCLES  1024  maximum HASH cycles to wait for core_done before flagging an error
// PORTS
//   clk          in   1    system clock, 50 MHz, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   msg_ready    in   1    buffer holds a complete padded block (level)
//   message_in   in   512  block from buffer; bits [511:504] are the first byte
//   msg_ack      out  1    one-cycle pulse: block captured, buffer may clear
//   core_block   out  512  registered block presented to the core
//   core_start   out  1    one-cycle pulse: start compression
//   core_done    in   1    one-cycle pulse: core_digest valid
//   core_digest  in   256  digest from core; bits [255:248] are the first byte
//   tx_data      out  8    byte to transmit, held stable until the next tx_start
//   tx_start     out  1    one-cycle pulse: transmitter loads tx_data
//   tx_busy      in   1    transmitter shifting a byte
//   busy         out  1    state != IDLE (combinational from the state register)
//   error        out  1    sticky watchdog flag; cleared when the next block is accepted
// BEHAVIOUR
//   Reset (async): state=IDLE; all outputs, core_block, digest register, byte index and timer = 0.
//     - Reset in any state aborts with no further pulses; a partial digest is discarded.
//   All outputs registered except busy.
//   States: IDLE, START, HASH, SEND, GAP, WAIT_TX.
//   IDLE:    msg_ready=1 -> capture message_in into core_block; msg_ack=1 for 1 cycle;
//            error<=0; go START.
//   START:   core_start=1 for 1 cycle; timer<=0; go HASH.
//   HASH:    timer++ each cycle.
//            core_done=1 -> latch core_digest; idx<=0; go SEND.
//            timer==TIMEOUT_CYCLES-1 without core_done -> error<=1; go IDLE; no bytes sent.
//            If core_done arrives on the timeout cycle, core_done wins.
//   SEND:    tx_busy=0 -> tx_data<=digest[255-8*idx -:8]; tx_start=1 for 1 cycle; go GAP.
//            tx_busy=1 -> stay.
//   GAP:     one cycle with tx_busy ignored; covers the transmitter's 1-cycle busy latency; go WAIT_TX.
//   WAIT_TX: wait for tx_busy=0.
//            idx==DIGEST_BYTES-1 -> go IDLE.
//            Otherwise idx++ and go SEND.
//   Latency:
//     - msg_ready sampled high at edge N (IDLE) -> msg_ack high in cycle N+1, core_start in N+2.
//     - core_done sampled at edge N -> first tx_start in cycle N+2 if tx_busy=0.
//   Handshake and boundary rules:
//     - msg_ready outside IDLE is ignored with no msg_ack; the buffer holds until acked.
//     - A block pending at return to IDLE is accepted on the next cycle.
//     - core_done outside HASH is ignored.
//     - tx_start never asserts while tx_busy=1.
//     - Exactly DIGEST_BYTES tx_start pulses per successful block.
//     - idx never wraps inside a digest; it resets to 0 on each new digest.
//     - msg_ack and core_start are never high in the same cycle.
// TESTING
//   1 "hi" block (68 69 80 00..00 0010) -> msg_ack 1 cycle, core_start the next cycle, core_block==input.
//     Model core returns done after 64 cycles with digest 8f434346...dc327aa4.
//     TX bytes 8f,43,43,46,...,7a,a4 in order (32 total), then busy=0.
//   2 Backpressure: model holds tx_busy high 200 cycles per byte -> 32 tx_start pulses,
//     none while tx_busy=1, byte order intact.
//   3 Watchdog: core_done never asserted -> error=1 at HASH cycle 1024, busy=0, zero tx_start.
//     The next accepted block clears error.
//   4 msg_ready asserted during SEND -> no msg_ack until IDLE.
//     Then acked and hashed; the first digest completes uninterrupted.
//   5 rst_n low after byte 10 -> all outputs 0 immediately, no further tx_start.
//     A new block after reset streams from byte 0.
//   6 core_done pulsed in IDLE and in SEND -> ignored: no extra tx_start, digest unchanged.

Source files
------------

// File: rtl/sha256_digest_ctrl.sv
// rtl/sha256_digest_ctrl.sv - SHA-256 block/digest sequencer between message buffer, core and UART TX
// Captures a block, starts the core under a watchdog, then streams the latched digest MSB-byte-first.
module sha256_digest_ctrl #(
  parameter int DIGEST_BYTES   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      msg_ready,
  input  logic [511:0]              message_in,
  output logic                      msg_ack,
  output logic [511:0]              core_block,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [8*DIGEST_BYTES-1:0] core_digest,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      busy,
  output logic                      error
);

  localparam int DW = 8 * DIGEST_BYTES;
  localparam int IW = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGEST_BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HASH,
    S_SEND,
    S_GAP,
    S_WAIT_TX
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_msg_ack;
  logic            r_core_start;
  logic            r_tx_start;
  logic            r_error;
  logic [511:0]    r_core_block;
  logic [DW-1:0]   r_digest;
  logic [7:0]      r_tx_data;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_timer;

  logic            w_accept;
  logic            w_start_core;
  logic            w_done;
  logic            w_timeout;
  logic            w_send;
  logic            w_advance;
  logic [7:0]      w_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // core_done is checked before the watchdog so a completion on the last cycle still wins.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start_core = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_send       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (msg_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_start_core = 1'b1;
        w_next_state = S_HASH;
      end
      S_HASH: begin
        if (core_done) begin
          w_done       = 1'b1;
          w_next_state = S_SEND;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_send       = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        w_next_state = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          if (r_idx == IDX_LAST) begin
            w_next_state = S_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = S_SEND;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_byte = r_digest[DW-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_ack    <= 1'b0;
      r_core_start <= 1'b0;
      r_tx_start   <= 1'b0;
      r_error      <= 1'b0;
      r_core_block <= '0;
      r_digest     <= '0;
      r_tx_data    <= 8'h00;
      r_idx        <= '0;
      r_timer      <= '0;
    end else begin
      r_msg_ack    <= w_accept;
      r_core_start <= w_start_core;
      r_tx_start   <= w_send;
      if (w_accept) begin
        r_core_block <= message_in;
        r_error      <= 1'b0;
      end else if (w_timeout) begin
        r_error      <= 1'b1;
      end
      if (w_start_core) begin
        r_timer <= '0;
      end else if (r_state == S_HASH) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_done) begin
        r_digest <= core_digest;
        r_idx    <= '0;
      end else if (w_advance) begin
        r_idx    <= r_idx + IW'(1);
      end
      if (w_send) begin
        r_tx_data <= w_byte;
      end
    end
  end

  assign msg_ack    = r_msg_ack;
  assign core_start = r_core_start;
  assign core_block = r_core_block;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign error      = r_error;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sha256_digest_ctrl.sv
// tb/tb_sha256_digest_ctrl.sv - directed bench for sha256_digest_ctrl with core and UART TX models
module tb_sha256_digest_ctrl;

  localparam int NB = 32;
  localparam logic [511:0] HI_BLOCK = {8'h68, 8'h69, 8'h80, 424'h0, 64'h10};
  localparam logic [255:0] HI_DIG   =
    256'h8f434346648f6b96df89dda901c5176b10a6d83961dd3c1ac88b59b2dc327aa4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_ready = 1'b0;
  logic [511:0] message_in = '0;
  logic         msg_ack;
  logic [511:0] core_block;
  logic         core_start;
  logic         core_done;
  logic [255:0] core_digest;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic         busy;
  logic         error;

  int checks = 0;
  int failures = 0;

  logic         core_en = 1'b1;
  int           core_lat = 64;
  int           core_cnt = -1;
  logic         m_done = 1'b0;
  logic         inj_done = 1'b0;
  logic [255:0] cur_dig = '0;
  int           tx_hold = 3;
  int           busy_cnt = 0;
  int           ncnt = 0;
  int           done_neg = 0;
  logic [7:0]   rx_q[$];
  int           rx_neg[$];

  typedef struct {
    logic [511:0] msg;
    logic [255:0] dig;
    int           lat;
    int           hold;
  } vec_t;
  vec_t vecs[3];

  assign core_done   = m_done | inj_done;
  assign core_digest = cur_dig;

  sha256_digest_ctrl #(.DIGEST_BYTES(NB), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .msg_ready(msg_ready), .message_in(message_in),
    .msg_ack(msg_ack), .core_block(core_block), .core_start(core_start),
    .core_done(core_done), .core_digest(core_digest), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .error(error)
  );

  always #10 clk = ~clk;

  always @(posedge clk) ncnt <= ncnt + 1;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Compression core: done pulse core_lat cycles after core_start is seen.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      core_cnt = -1;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
      end else if (core_cnt == 0) begin
        m_done   = 1'b1;
        done_neg = ncnt;
        core_cnt = -1;
      end
      if (core_start && core_en) core_cnt = core_lat - 1;
    end
  end

  // UART transmitter: goes busy for tx_hold cycles after each load.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (tx_start) begin
        check("tx_start_while_busy", tx_busy, 0);
        rx_q.push_back(tx_data);
        rx_neg.push_back(ncnt);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_start && tx_hold > 0) begin
        tx_busy  = 1'b1;
        busy_cnt = tx_hold;
      end
    end
  end

  task automatic start_block(input logic [511:0] msg, output int n);
    message_in = msg;
    msg_ready  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_ack && n < 3000);
    check("ack_seen", msg_ack, 1);
    check("core_block", core_block, msg);
    check("error_cleared", error, 0);
    check("ack_not_with_start", core_start, 0);
    msg_ready = 1'b0;
    @(negedge clk);
    check("core_start_pulse", core_start, 1);
    check("ack_one_cycle", msg_ack, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_bytes(input logic [255:0] dig, input int base, input string tag);
    logic [255:0] d;
    logic [7:0]   a;
    d = dig;
    check({tag, "_byte_count"}, rx_q.size() - base, NB);
    for (int i = 0; i < NB; i++) begin
      a = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), a, d[255 - 8*i -: 8]);
    end
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int base;
    int n;
    cur_dig  = v.dig;
    core_lat = v.lat;
    tx_hold  = v.hold;
    base     = rx_q.size();
    start_block(v.msg, n);
    check({tag, "_ack_latency"}, n, 1);
    wait_idle(tag);
    check_bytes(v.dig, base, tag);
    if (rx_q.size() > base) check({tag, "_first_tx_latency"}, rx_neg[base] - done_neg, 2);
  endtask

  initial begin
    #(60000 * 20);
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int cnt;
    vecs[0] = '{HI_BLOCK, HI_DIG, 64, 3};
    vecs[1] = '{{16{32'hdeadbeef}},
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 10, 200};
    vecs[2] = '{{64{8'ha5}},
                256'hff00ff0180fe7f0255aa33cc0f0ff0f0123456789abcdef0fedcba9876543210, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_msg_ack", msg_ack, 0);
    check("rst_core_start", core_start, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_core_block", core_block, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Watchdog: core never answers.
    core_en = 1'b0;
    base = rx_q.size();
    start_block(HI_BLOCK, n);
    cnt = 1;
    while (!error && cnt < 1200) begin
      @(negedge clk);
      cnt++;
    end
    check("wd_error_set", error, 1);
    check("wd_cycles", cnt, 1025);
    check("wd_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("wd_error_sticky", error, 1);
    check("wd_no_tx", rx_q.size() - base, 0);
    core_en = 1'b1;
    run_block(vecs[2], "wd_recover");

    // New block requested while a digest is streaming.
    cur_dig = HI_DIG; core_lat = 16; tx_hold = 20;
    base = rx_q.size();
    start_block(HI_BLOCK, n);
    cnt = 0;
    while (rx_q.size() <= base && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    message_in = vecs[1].msg;
    msg_ready  = 1'b1;
    cnt = 0;
    while (!msg_ack && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("pend_ack_seen", msg_ack, 1);
    check("pend_ack_after_digest", rx_q.size() - base, NB);
    check("pend_core_block", core_block, vecs[1].msg);
    msg_ready = 1'b0;
    check_bytes(HI_DIG, base, "pend_first");
    @(negedge clk);
    check("pend_core_start", core_start, 1);
    wait_idle("pend");
    check_bytes(HI_DIG, base + NB, "pend_second");

    // core_done outside HASH.
    base = rx_q.size();
    cur_dig  = 256'h1;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_done_busy", busy, 0);
    check("idle_done_no_tx", rx_q.size() - base, 0);
    cur_dig = vecs[1].dig; core_lat = 5; tx_hold = 4;
    start_block(HI_BLOCK, n);
    cnt = 0;
    while (rx_q.size() < base + 3 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    cur_dig  = {8{32'hcafef00d}};
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    wait_idle("send_done");
    check_bytes(vecs[1].dig, base, "send_done");

    // Reset mid-stream.
    cur_dig = HI_DIG; core_lat = 8; tx_hold = 5;
    base = rx_q.size();
    start_block(HI_BLOCK, n);
    cnt = 0;
    while (rx_q.size() < base + 10 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_core_block", core_block, 0);
    check("mid_rst_ack_start", {msg_ack, core_start, error}, 0);
    cnt = rx_q.size();
    check("mid_rst_bytes_sent", cnt - base, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_more_tx", rx_q.size(), cnt);
    check("mid_rst_idle", busy, 0);
    run_block('{HI_BLOCK, HI_DIG, 64, 3}, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
